// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam int FWD_NONE = 0;

    // Width of the per-record ready down-counter; bounds LOAD_LAT/MUL_LAT.
    localparam int RDY_W = 4;

    typedef struct packed {
        logic             valid;
        logic [4:0]       rd;
        logic [RDY_W-1:0] rdy;
    } hz_rec_t;

endpackage

// File: rtl/hazard_decode.sv
// Operand usage / destination / result-latency decode of the ID instruction.
// Multiply latency tagging is built only when HAZ_MUL_EN is defined.
module hazard_decode
    import hazard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 1
`ifdef HAZ_MUL_EN
    , parameter int MUL_LAT = 2
`endif
) (
    input  logic [XLEN-1:0]  inst_i,
    output logic             rs1_used_o,
    output logic             rs2_used_o,
    output logic             rd_wr_o,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [RDY_W-1:0] rdy_init_o
);
    logic [6:0] opc;
    logic       unused_bits;

    assign opc         = inst_i[6:0];
    assign rd_o        = inst_i[11:7];
    assign rs1_o       = inst_i[19:15];
    assign rs2_o       = inst_i[24:20];
    assign unused_bits = ^inst_i;

    always_comb begin
        rs1_used_o = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
        rs2_used_o = (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
        rd_wr_o    = !(opc == OPC_BRANCH || opc == OPC_STORE);
        rdy_init_o = '0;
        if (opc == OPC_LOAD)
            rdy_init_o = RDY_W'(LOAD_LAT);
`ifdef HAZ_MUL_EN
        if (opc == OPC_OP && inst_i[31:25] == 7'b0000001)
            rdy_init_o = RDY_W'(MUL_LAT);
`endif
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of post-ID destination records driving operand
// forwarding selects and the load-use / multi-cycle stall. Option: HAZ_MUL_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 2,
    parameter int SEL_W    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_inst,
    input  logic             hold,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_rs1,
    output logic [SEL_W-1:0] fwd_rs2,
    output logic             stall,
    output logic [31:0]      stall_cnt
);
    localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;

    generate
        if (DEPTH < MAX_LAT + 1) begin : g_depth_err
            $error("hazard_scoreboard: DEPTH must be >= max(LOAD_LAT, MUL_LAT) + 1");
        end
        if (MAX_LAT >= (1 << RDY_W)) begin : g_lat_err
            $error("hazard_scoreboard: latency does not fit the ready counter");
        end
        if (XLEN < 32) begin : g_xlen_err
            $error("hazard_scoreboard: XLEN must be at least 32");
        end
    endgenerate

    logic             rs1_used, rs2_used, rd_wr;
    logic [4:0]       rd, rs1, rs2;
    logic [RDY_W-1:0] rdy_init;

    hazard_decode #(
        .XLEN     (XLEN),
        .LOAD_LAT (LOAD_LAT)
`ifdef HAZ_MUL_EN
        , .MUL_LAT (MUL_LAT)
`endif
    ) u_decode (
        .inst_i     (id_inst),
        .rs1_used_o (rs1_used),
        .rs2_used_o (rs2_used),
        .rd_wr_o    (rd_wr),
        .rd_o       (rd),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .rdy_init_o (rdy_init)
    );

    hz_rec_t          rec_q [1:DEPTH];
    hz_rec_t          rec_d [1:DEPTH];
    logic [31:0]      cnt_q, cnt_d;
    logic [SEL_W-1:0] sel1, sel2;
    logic             pend1, pend2, use1, use2, ins;

    // Scan oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        sel1  = SEL_W'(FWD_NONE);
        sel2  = SEL_W'(FWD_NONE);
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (rec_q[k].valid && rec_q[k].rd == rs1 && rs1 != 5'd0) begin
                pend1 = (rec_q[k].rdy != '0);
                sel1  = pend1 ? SEL_W'(FWD_NONE) : SEL_W'(k);
            end
            if (rec_q[k].valid && rec_q[k].rd == rs2 && rs2 != 5'd0) begin
                pend2 = (rec_q[k].rdy != '0);
                sel2  = pend2 ? SEL_W'(FWD_NONE) : SEL_W'(k);
            end
        end
    end

    assign use1      = id_valid & rs1_used;
    assign use2      = id_valid & rs2_used;
    assign fwd_rs1   = use1 ? sel1 : SEL_W'(FWD_NONE);
    assign fwd_rs2   = use2 ? sel2 : SEL_W'(FWD_NONE);
    assign stall     = (use1 & pend1) | (use2 & pend2);
    assign stall_cnt = cnt_q;

    // A stalled or flushed ID op never enters EX; flush dominates stall.
    assign ins = id_valid & ~stall & ~flush & rd_wr & (rd != 5'd0);

    always_comb begin
        rec_d = rec_q;
        cnt_d = cnt_q;
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                rec_d[k]     = rec_q[k-1];
                rec_d[k].rdy = (rec_q[k-1].rdy == '0) ? '0 : rec_q[k-1].rdy - 1'b1;
            end
            rec_d[1] = '0;
            if (ins) begin
                rec_d[1].valid = 1'b1;
                rec_d[1].rd    = rd;
                rec_d[1].rdy   = rdy_init;
            end
            if (stall)
                cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++)
                rec_q[k] <= '0;
            cnt_q <= '0;
        end else begin
            rec_q <= rec_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed RV32 sequences plus a
// random phase, against an independent record model via an expectation queue.
module tb_hazard_scoreboard;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 2;
    localparam int SEL_W    = $clog2(DEPTH+1);
`ifdef HAZ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, id_valid, hold, flush;
    logic [XLEN-1:0]  id_inst;
    logic [SEL_W-1:0] fwd_rs1, fwd_rs2;
    logic             stall;
    logic [31:0]      stall_cnt;

    hazard_scoreboard #(
        .XLEN(XLEN), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
        .hold(hold), .flush(flush), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEL_W-1:0] f1;
        logic [SEL_W-1:0] f2;
        logic             st;
        logic [31:0]      cnt;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    bit          mv   [1:DEPTH];
    logic [4:0]  mrd  [1:DEPTH];
    int          mrdy [1:DEPTH];
    logic [31:0] mcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] s_op(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction

    function automatic void model_clear();
        for (int k = 1; k <= DEPTH; k++) begin
            mv[k] = 1'b0; mrd[k] = 5'd0; mrdy[k] = 0;
        end
        mcnt = 32'd0;
    endfunction

    function automatic void model_match(input logic [4:0] rs, input bit used,
                                        output int sel, output bit pend);
        sel  = 0;
        pend = 1'b0;
        if (used && rs != 5'd0) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (mv[k] && mrd[k] == rs) begin
                    if (mrdy[k] == 0) sel = k;
                    else pend = 1'b1;
                    break;
                end
            end
        end
    endfunction

    // Drive one ID cycle, compare at the falling edge, then advance the model.
    task automatic step(input string tag, input logic [31:0] inst, input bit v,
                        input bit h, input bit f);
        logic [6:0] opc;
        bit   u1, u2, wr, p1, p2, st;
        int   s1, s2, lat;
        exp_t e;
        id_inst = inst; id_valid = v; hold = h; flush = f;
        opc = inst[6:0];
        u1  = !(opc inside {7'h37, 7'h17, 7'h6f});
        u2  = (opc inside {7'h63, 7'h23, 7'h33});
        wr  = !(opc inside {7'h63, 7'h23});
        lat = (opc == 7'h03) ? LOAD_LAT :
              (MUL_EN && opc == 7'h33 && inst[31:25] == 7'h01) ? MUL_LAT : 0;
        model_match(inst[19:15], v && u1, s1, p1);
        model_match(inst[24:20], v && u2, s2, p2);
        st = p1 | p2;
        e.f1 = SEL_W'(s1); e.f2 = SEL_W'(s2); e.st = st; e.cnt = mcnt;
        expq.push_back(e);
        @(negedge clk);
        e = expq.pop_front();
        check({tag, ".fwd_rs1"}, 32'(fwd_rs1), 32'(e.f1));
        check({tag, ".fwd_rs2"}, 32'(fwd_rs2), 32'(e.f2));
        check({tag, ".stall"},   32'(stall),   32'(e.st));
        check({tag, ".cnt"},     stall_cnt,    e.cnt);
        @(posedge clk);
        if (!h) begin
            for (int k = DEPTH; k >= 2; k--) begin
                mv[k] = mv[k-1]; mrd[k] = mrd[k-1];
                mrdy[k] = (mrdy[k-1] > 0) ? mrdy[k-1] - 1 : 0;
            end
            mv[1]   = v && !st && !f && wr && inst[11:7] != 5'd0;
            mrd[1]  = inst[11:7];
            mrdy[1] = lat;
            if (st) mcnt = mcnt + 32'd1;
        end
        #1;
    endtask

    initial begin
        logic [6:0] opcs [8];
        logic [6:0] f7s  [3];
        logic [31:0] ri;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h17};
        f7s  = '{7'h00, 7'h20, 7'h01};
        model_clear();
        rst = 1'b1; id_valid = 1'b0; id_inst = '0; hold = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("reset.fwd_rs1", 32'(fwd_rs1), 32'd0);
        check("reset.stall",   32'(stall),   32'd0);
        check("reset.cnt",     stall_cnt,    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        step("idle",    r_op(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0, 1'b0, 1'b0);
        // add x3 ; sub x4,x3,x1 ; or x5,x3,x0
        step("add3",    r_op(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 1'b0, 1'b0);
        step("sub4",    r_op(7'h20, 5'd1, 5'd3, 3'd0, 5'd4), 1'b1, 1'b0, 1'b0);
        check("sub4.direct", 32'(mrd[2]), 32'd3);
        step("or5",     r_op(7'h00, 5'd0, 5'd3, 3'd6, 5'd5), 1'b1, 1'b0, 1'b0);
        // load-use
        step("lw6",     i_op(12'd0, 5'd2, 3'd2, 5'd6, 7'h03), 1'b1, 1'b0, 1'b0);
        step("use6a",   r_op(7'h00, 5'd6, 5'd6, 3'd0, 5'd7), 1'b1, 1'b0, 1'b0);
        step("use6b",   r_op(7'h00, 5'd6, 5'd6, 3'd0, 5'd7), 1'b1, 1'b0, 1'b0);
        check("loaduse.cnt", stall_cnt, 32'd1);
        // x0 destination and store never create records
        step("addi0",   i_op(12'd5, 5'd1, 3'd0, 5'd0, 7'h13), 1'b1, 1'b0, 1'b0);
        step("add8",    r_op(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), 1'b1, 1'b0, 1'b0);
        step("sw9",     s_op(12'd9, 5'd9, 5'd1), 1'b1, 1'b0, 1'b0);
        step("use9",    r_op(7'h00, 5'd9, 5'd9, 3'd0, 5'd12), 1'b1, 1'b0, 1'b0);
        // youngest wins, then hold
        step("add3a",   r_op(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 1'b0, 1'b0);
        step("add3b",   r_op(7'h00, 5'd1, 5'd2, 3'd0, 5'd3), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hold3",  r_op(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 1'b1, 1'b1, 1'b0);
        step("young",   r_op(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 1'b1, 1'b0, 1'b0);
        // stall held frozen: counter must not move
        step("lw6h",    i_op(12'd0, 5'd2, 3'd2, 5'd6, 7'h03), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hstall", r_op(7'h00, 5'd6, 5'd1, 3'd0, 5'd7), 1'b1, 1'b1, 1'b0);
        step("hrel",    r_op(7'h00, 5'd6, 5'd1, 3'd0, 5'd7), 1'b1, 1'b0, 1'b0);
        // flush during load-use stall
        step("lw12",    i_op(12'd4, 5'd2, 3'd2, 5'd12, 7'h03), 1'b1, 1'b0, 1'b0);
        step("flush13", r_op(7'h00, 5'd1, 5'd12, 3'd0, 5'd13), 1'b1, 1'b0, 1'b1);
        step("use13",   r_op(7'h00, 5'd12, 5'd13, 3'd6, 5'd14), 1'b1, 1'b0, 1'b0);
        // multiply latency (stalls only when the feature is built)
        step("mul10",   r_op(7'h01, 5'd2, 5'd1, 3'd0, 5'd10), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("use10",  r_op(7'h00, 5'd1, 5'd10, 3'd0, 5'd11), 1'b1, 1'b0, 1'b0);
        // lui/jal ignore rs1 field
        step("lui",     32'h0001_8137, 1'b1, 1'b0, 1'b0);
        step("jal",     32'h0001_00ef, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ri = {f7s[$urandom_range(0, 2)], 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                  3'd0, 5'($urandom_range(0, 5)), opcs[$urandom_range(0, 7)]};
            step("rand", ri, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 9) == 0);
        end

        // asynchronous reset in the middle of activity
        step("prerst",  i_op(12'd0, 5'd2, 3'd2, 5'd6, 7'h03), 1'b1, 1'b0, 1'b0);
        id_inst = r_op(7'h00, 5'd6, 5'd6, 3'd0, 5'd7); id_valid = 1'b1; hold = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst.fwd_rs1", 32'(fwd_rs1), 32'd0);
        check("midrst.fwd_rs2", 32'(fwd_rs2), 32'd0);
        check("midrst.stall",   32'(stall),   32'd0);
        check("midrst.cnt",     stall_cnt,    32'd0);
        model_clear();
        #2 rst = 1'b0;
        @(posedge clk); #1;
        step("postrst", r_op(7'h00, 5'd6, 5'd6, 3'd0, 5'd7), 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
